burst_mem_responder: RTL
========================

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width.
REQ-002 Parameter DATA_WIDTH, 32, beat width; a power of 2, at least 8.
REQ-003 Parameter BURST_LEN_WIDTH, 3, width of burst length field.
REQ-004 Parameter DEPTH_WORDS, 1024, storage depth in beats; a power of 2.
REQ-005 Parameter RD_LATENCY, 2, cycles from read acceptance to first rd_valid; at least 1.
REQ-006 Port clock, input, 1, single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-high reset.
REQ-008 Port mem_addr, input, ADDR_WIDTH, byte address of the request.
REQ-009 Port mem_burst_len, input, BURST_LEN_WIDTH, beats minus one (0 means 1 beat).
REQ-010 Port mem_rd, input, 1, read burst request.
REQ-011 Port mem_wr, input, 1, write beat valid.
REQ-012 Port mem_wr_data, input, DATA_WIDTH, write beat data.
REQ-013 Port mem_rd_data, output, DATA_WIDTH, read beat data.
REQ-014 Port mem_rd_valid, output, 1, read beat strobe.
REQ-015 Port mem_waitrequest, output, 1, registered; high means the responder accepts nothing this cycle.
REQ-016 Port proto_err, output, 1, sticky protocol-violation flag.

Function
REQ-017 The block SHALL implement states IDLE, WR_BURST, RD_WAIT and RD_BURST.
REQ-018 mem_waitrequest SHALL be low in IDLE and WR_BURST, and high in RD_WAIT and RD_BURST; it is a registered function of next state.
REQ-019 A beat or request SHALL be accepted only in a cycle where it is asserted and mem_waitrequest is low.
REQ-020 Burst base SHALL be mem_addr word index (mem_addr >> log2(DATA_WIDTH/8)) with its low log2(burst_len+1) bits cleared (line aligned); burst_len+1 SHALL be a power of 2.
REQ-021 Storage index SHALL be (base + beat) modulo DEPTH_WORDS; out-of-range addresses wrap silently.
REQ-022 IDLE with mem_wr accepted: SHALL write beat 0, latch base and burst_len, set beat counter to 1, and go to WR_BURST; a burst_len of 0 returns to IDLE instead.
REQ-023 WR_BURST: each cycle with mem_wr high SHALL write beat n and increment the counter; cycles with mem_wr low SHALL stall with no write; after beat burst_len the block SHALL go to IDLE.
REQ-024 Within a write burst, mem_addr and mem_burst_len on beats after the first SHALL be ignored.
REQ-025 IDLE with mem_rd accepted (and mem_wr low): SHALL latch base and burst_len and go to RD_WAIT.
REQ-026 The first mem_rd_valid SHALL be high in the cycle following the RD_LATENCY-th rising edge after the acceptance edge; beats 0..burst_len SHALL then be driven on consecutive cycles with no gaps, ascending.
REQ-027 After the last read beat the block SHALL return to IDLE, with mem_waitrequest low in the cycle following that beat.
REQ-028 mem_rd_data SHALL be all zeros whenever mem_rd_valid is low.
REQ-029 mem_rd and mem_wr both accepted in IDLE: the write SHALL win, the read SHALL be dropped, and proto_err SHALL be set.
REQ-030 mem_rd high during WR_BURST SHALL be ignored and SHALL set proto_err.
REQ-031 Inputs during RD_WAIT and RD_BURST SHALL be ignored; proto_err is not set in those states.
REQ-032 Counters SHALL be BURST_LEN_WIDTH+1 bits wide so that burst_len of all ones does not overflow.

Reset
REQ-033 While reset is high, the block SHALL force state=IDLE, mem_waitrequest=1, mem_rd_valid=0, mem_rd_data=0 and proto_err=0, and clear the counters.
REQ-034 mem_waitrequest SHALL fall on the first rising edge after reset deasserts.
REQ-035 Reset mid-burst SHALL abort the burst; beats already written SHALL persist.
REQ-036 Storage contents SHALL NOT be reset.

Verification
REQ-037 Write burst: addr 0x100, len 3, data A0..A3 on consecutive cycles -> four beats accepted, waitrequest stays 0, state returns to IDLE.
REQ-038 Read-back: rd addr 0x104, len 3 -> with RD_LATENCY=2, rd_valid high on cycles +3..+6 carrying A0,A1,A2,A3 (aligned to 0x100); waitrequest high from +1 through +6.
REQ-039 Stalled write: len 3 with mem_wr low for 2 cycles between beats 1 and 2 -> no write during the gap, all 4 words correct, proto_err=0.
REQ-040 Collision: rd and wr both asserted in IDLE -> write performed, no rd_valid ever, proto_err=1 until reset.
REQ-041 Wrap: DEPTH_WORDS=1024, write addr 0x1000 len 0 data 0x5A -> a read of addr 0x0 returns 0x5A.
REQ-042 Reset asserted during RD_BURST beat 1 -> rd_valid=0 immediately; waitrequest=1 while in reset, then 0 on the first edge after release.

Source files
------------

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : burst_mem_responder
// Purpose  : Single-port burst memory slave. It accepts line-aligned write
//            bursts one beat per cycle, with stalls allowed. It serves read
//            bursts after a fixed latency as a gap-free stream of beats.
//            A sticky flag records requests that break the handshake rules.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock           : single clock, all logic on its rising edge
//   reset           : asynchronous, active-high reset
//   mem_addr        : byte address of the request (sampled on the first beat)
//   mem_burst_len   : beats minus one; beats = mem_burst_len + 1 (power of 2)
//   mem_rd          : read burst request
//   mem_wr          : write beat valid
//   mem_wr_data     : write beat data
//   mem_rd_data     : read beat data, all zeros whenever mem_rd_valid is low
//   mem_rd_valid    : read beat strobe
//   mem_waitrequest : registered busy flag; high means nothing is accepted
//   proto_err       : sticky protocol-violation flag, cleared only by reset
// ============================================================================
module burst_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 3,
    parameter int DEPTH_WORDS     = 1024,
    parameter int RD_LATENCY      = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [BURST_LEN_WIDTH-1:0] mem_burst_len,
    input  logic                       mem_rd,
    input  logic                       mem_wr,
    input  logic [DATA_WIDTH-1:0]      mem_wr_data,
    output logic [DATA_WIDTH-1:0]      mem_rd_data,
    output logic                       mem_rd_valid,
    output logic                       mem_waitrequest,
    output logic                       proto_err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // Number of byte-offset bits dropped to turn a byte address into a word index.
    localparam int c_BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    // Storage index width. Indices wrap modulo DEPTH_WORDS by truncation.
    localparam int c_IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // The beat counter is one bit wider than the length field, so an all-ones
    // length can count one past the last beat without wrapping.
    localparam int c_CNT_W      = BURST_LEN_WIDTH + 1;
    localparam int c_LAT_W      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(RD_LATENCY - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_BURST = 2'd1,
        S_RD_WAIT  = 2'd2,
        S_RD_BURST = 2'd3
    } state_t;

    state_t                     r_state;
    logic [c_IDX_W-1:0]         r_base;   // line-aligned index of beat 0
    logic [BURST_LEN_WIDTH-1:0] r_len;    // latched beats-minus-one
    logic [c_CNT_W-1:0]         r_beat;   // beat currently being transferred
    logic [c_LAT_W-1:0]         r_lat;    // read latency counter

    // Storage has no reset. Its contents survive reset and aborted bursts.
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------------
    // Address and handshake decode
    // ------------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_req_word;
    logic [c_IDX_W-1:0] w_len_mask;
    logic [c_IDX_W-1:0] w_req_base;
    logic [c_IDX_W-1:0] w_burst_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_CNT_W-1:0] w_len_ext;
    logic               w_wr_accept;
    logic               w_rd_accept;
    logic               w_unused_addr;

    // Only the index bits of the word address reach the array. Address bits
    // above them wrap silently, so their value does not matter.
    assign w_req_word    = mem_addr[c_BYTE_SHIFT +: c_IDX_W];
    assign w_unused_addr = ^mem_addr;

    // burst_len + 1 is a power of two, so burst_len is exactly the mask of
    // low index bits to clear for line alignment.
    assign w_len_mask  = c_IDX_W'(mem_burst_len);
    assign w_req_base  = w_req_word & ~w_len_mask;

    assign w_burst_idx = r_base + c_IDX_W'(r_beat);
    assign w_len_ext   = c_CNT_W'(r_len);

    // Waitrequest is high in both read states, so a write beat cannot be
    // accepted in either of them.
    assign w_wr_accept = mem_wr & ~mem_waitrequest;
    // A write wins a collision with a read, so the read is accepted only when
    // mem_wr is low.
    assign w_rd_accept = mem_rd & ~mem_wr & ~mem_waitrequest & (r_state == S_IDLE);

    // The first beat takes its index from the live request. Later beats take
    // it from the latched base, so mem_addr is ignored after the first beat.
    assign w_wr_idx    = (r_state == S_WR_BURST) ? w_burst_idx : w_req_base;

    // ------------------------------------------------------------------------
    // Storage write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_wr_accept) begin
            r_mem[w_wr_idx] <= mem_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            mem_waitrequest <= 1'b1;
            mem_rd_valid    <= 1'b0;
            mem_rd_data     <= '0;
            proto_err       <= 1'b0;
            r_base          <= '0;
            r_len           <= '0;
            r_beat          <= '0;
            r_lat           <= '0;
        end else begin
            // Read data is zero except in a cycle that carries a beat.
            mem_rd_valid <= 1'b0;
            mem_rd_data  <= '0;

            case (r_state)
                S_IDLE: begin
                    mem_waitrequest <= 1'b0;
                    if (w_wr_accept) begin
                        r_base <= w_req_base;
                        r_len  <= mem_burst_len;
                        r_beat <= c_CNT_ONE;
                        // A read presented with the accepted write is dropped.
                        if (mem_rd) begin
                            proto_err <= 1'b1;
                        end
                        // A single-beat write finishes here.
                        if (mem_burst_len != '0) begin
                            r_state <= S_WR_BURST;
                        end
                    end else if (w_rd_accept) begin
                        r_base          <= w_req_base;
                        r_len           <= mem_burst_len;
                        r_beat          <= '0;
                        r_lat           <= '0;
                        r_state         <= S_RD_WAIT;
                        mem_waitrequest <= 1'b1;
                    end
                end

                S_WR_BURST: begin
                    mem_waitrequest <= 1'b0;
                    if (mem_rd) begin
                        proto_err <= 1'b1;
                    end
                    // A cycle with mem_wr low is a stall. Nothing advances.
                    if (mem_wr) begin
                        if (r_beat == w_len_ext) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + c_CNT_ONE;
                        end
                    end
                end

                S_RD_WAIT: begin
                    mem_waitrequest <= 1'b1;
                    // On the RD_LATENCY-th edge after acceptance, beat 0 is
                    // registered onto the bus for the following cycle.
                    if (r_lat == c_LAT_LAST) begin
                        mem_rd_valid <= 1'b1;
                        mem_rd_data  <= r_mem[w_burst_idx];
                        r_beat       <= r_beat + c_CNT_ONE;
                        r_state      <= S_RD_BURST;
                    end else begin
                        r_lat <= r_lat + c_LAT_ONE;
                    end
                end

                S_RD_BURST: begin
                    if (r_beat <= w_len_ext) begin
                        mem_waitrequest <= 1'b1;
                        mem_rd_valid    <= 1'b1;
                        mem_rd_data     <= r_mem[w_burst_idx];
                        r_beat          <= r_beat + c_CNT_ONE;
                    end else begin
                        // The last beat is on the bus this cycle. Ready again
                        // in the next one.
                        mem_waitrequest <= 1'b0;
                        r_beat          <= '0;
                        r_state         <= S_IDLE;
                    end
                end

                default: begin
                    mem_waitrequest <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
